// File: rtl/sprite_blit_ctrl.sv
// Sprite blitter: copies a 64x64 1bpp sprite from ROM into the frame-buffer SPRAM
// and arbitrates the SPRAM port, giving display reads absolute priority.
module sprite_blit_ctrl #(
  parameter int unsigned FB_STRIDE   = 40,
  parameter int unsigned FB_ROWS     = 400,
  parameter int unsigned ROM_LAT     = 2,
  parameter int unsigned SPR_WORDS_X = 4,
  parameter int unsigned SPR_ROWS    = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [1:0]  i_sprite_sel,
  input  logic [5:0]  i_dst_wx,
  input  logic [8:0]  i_dst_y,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_rom_sel,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_dout,
  input  logic        i_disp_req,
  input  logic [13:0] i_disp_addr,
  output logic [15:0] o_disp_data,
  output logic        o_disp_valid,
  output logic        o_ram_wr_en,
  output logic [13:0] o_ram_addr,
  output logic [15:0] o_ram_din,
  input  logic [15:0] i_ram_dout
);

  localparam int unsigned ROW_W  = $clog2(SPR_ROWS);
  localparam int unsigned COL_W  = $clog2(SPR_WORDS_X);
  localparam int unsigned WAIT_W = (ROM_LAT > 2) ? $clog2(ROM_LAT) : 1;
  localparam int unsigned AW     = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLIPCHK,
    S_FETCH,
    S_WAIT,
    S_WRITE,
    S_FIN
  } state_t;

  state_t              r_state;
  logic [ROW_W-1:0]    r_row;
  logic [COL_W-1:0]    r_col;
  logic [WAIT_W-1:0]   r_wait;
  logic [1:0]          r_sel;
  logic [5:0]          r_wx;
  logic [8:0]          r_y;
  logic                r_busy;
  logic                r_done;
  logic [7:0]          r_rom_addr;
  logic                r_disp_valid;

  logic                w_clip;
  logic                w_advance;
  logic                w_col_last;
  logic                w_last;
  logic [13:0]         w_blit_addr;
  logic [7:0]          w_rom_addr;

  // Destination coordinates are widened so off-screen positions never wrap.
  assign w_clip = ((AW'(r_y) + AW'(r_row)) >= AW'(FB_ROWS)) ||
                  ((AW'(r_wx) + AW'(r_col)) >= AW'(FB_STRIDE));

  assign w_blit_addr = 14'((AW'(r_y) + AW'(r_row)) * AW'(FB_STRIDE) + AW'(r_wx) + AW'(r_col));
  assign w_rom_addr  = 8'(AW'(r_row) * AW'(SPR_WORDS_X) + AW'(r_col));

  assign w_col_last = (r_col == COL_W'(SPR_WORDS_X - 1));
  assign w_last     = w_col_last && (r_row == ROW_W'(SPR_ROWS - 1));
  assign w_advance  = ((r_state == S_CLIPCHK) && w_clip) ||
                      ((r_state == S_WRITE) && !i_disp_req);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_wait       <= '0;
      r_sel        <= '0;
      r_wx         <= '0;
      r_y          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rom_addr   <= '0;
      r_disp_valid <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_disp_valid <= i_disp_req;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_sel   <= i_sprite_sel;
            r_wx    <= i_dst_wx;
            r_y     <= i_dst_y;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CLIPCHK;
          end
        end
        S_CLIPCHK: begin
          if (!w_clip) begin
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_rom_addr <= w_rom_addr;
          r_wait     <= WAIT_W'(ROM_LAT - 1);
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait == '0) begin
            r_state <= S_WRITE;
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end
        S_WRITE: begin
          // Display owns the port while it requests; the blit word waits here.
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Word finished (written or clipped): step the sprite raster.
      if (w_advance) begin
        if (w_last) begin
          r_row   <= '0;
          r_col   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_FIN;
        end else begin
          r_state <= S_CLIPCHK;
          if (w_col_last) begin
            r_col <= '0;
            r_row <= r_row + ROW_W'(1);
          end else begin
            r_col <= r_col + COL_W'(1);
          end
        end
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_rom_sel    = r_sel;
  assign o_rom_addr   = r_rom_addr;
  assign o_disp_valid = r_disp_valid;
  assign o_disp_data  = i_ram_dout;

  // Port arbitration: display read wins, blit write only when the port is free.
  assign o_ram_wr_en = (r_state == S_WRITE) && !i_disp_req;
  assign o_ram_addr  = i_disp_req ? i_disp_addr : (r_busy ? w_blit_addr : '0);
  assign o_ram_din   = (r_state == S_WRITE) ? i_rom_dout : '0;

endmodule

// File: doc/sprite_blit_ctrl.md
Name: sprite_blit_ctrl

Overview:
Sequencer that copies one 64x64 1bpp sprite (256 x 16-bit words) from a selected sprite ROM into the single-port frame-buffer SPRAM at a word-aligned destination. It also arbitrates that SPRAM between the display scan-out reader, which has absolute priority, and the blitter's own writes. It sits between the sprite ROM bank (2-cycle registered read), the frame-buffer SPRAM (1-cycle read latency, write-enable) and the display engine.

Parameters:
FB_STRIDE, 40, frame-buffer row length in 16-bit words (640 px).
FB_ROWS, 400, frame-buffer rows.
ROM_LAT, 2, cycles from rom_addr stable to rom_dout valid.
SPR_WORDS_X, 4, sprite row length in words.
SPR_ROWS, 64, sprite rows.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  1-cycle pulse: begin blit; sampled only in IDLE
sprite_sel  in  2  ROM index, latched on accepted start
dst_wx  in  6  destination word column, latched on start
dst_y  in  9  destination row, latched on start
busy  out  1  high from cycle after accepted start until done
done  out  1  1-cycle pulse when blit completes
rom_sel  out  2  latched sprite_sel, drives external ROM mux
rom_addr  out  8  sprite word address (row*4 + col)
rom_dout  in  16  sprite ROM data
disp_req  in  1  display read request for this cycle
disp_addr  in  14  display read address
disp_data  out  16  SPRAM read data, passthrough of ram_dout
disp_valid  out  1  disp_req delayed one cycle (registered)
ram_wr_en  out  1  SPRAM write enable
ram_addr  out  14  SPRAM address
ram_din  out  16  SPRAM write data
ram_dout  in  16  SPRAM read data

Behaviour:
- Reset: state IDLE, busy=0, done=0, disp_valid=0, rom_sel=0, rom_addr=0, row/col counters=0, wait counter=0. A reset during a blit aborts it: no further writes, no done pulse.
- FSM states: IDLE, CLIPCHK, FETCH, WAIT, WRITE, FIN.
- IDLE: on start, latch sprite_sel/dst_wx/dst_y, clear row r and col c, go to CLIPCHK. start while not IDLE is ignored.
- CLIPCHK: if dst_y+r >= FB_ROWS or dst_wx+c >= FB_STRIDE, the word is clipped. No ROM fetch, no write; advance. Otherwise go to FETCH.
- FETCH: drive rom_addr = r*SPR_WORDS_X + c, load wait counter, go to WAIT. rom_addr stays stable until the next FETCH.
- WAIT: count ROM_LAT cycles, then go to WRITE.
- WRITE: if disp_req=0, assert ram_wr_en with ram_addr = (dst_y+r)*FB_STRIDE + dst_wx + c and ram_din = rom_dout, then advance. If disp_req=1, stay in WRITE with no write (stall, unbounded).
- Advance: increment c; when c wraps at SPR_WORDS_X, set c=0 and increment r. After the last word (r=63, c=3), go to FIN, else go to CLIPCHK.
- FIN: done=1 for exactly one cycle, busy drops the same cycle, return to IDLE.
- Address arithmetic is done at >=15 bits and truncated to 14. After clipping the result is always <= 15999.
- Arbitration is combinational from registered state:
  - ram_addr = disp_req ? disp_addr : blit address.
  - ram_wr_en = (state==WRITE) && !disp_req, so a blit write never coincides with a display read.
  - When idle with no disp_req, ram_addr = 0 and ram_wr_en = 0.
- disp_valid is registered disp_req. disp_data is ram_dout unmodified.
- Timing with no contention and no clipping: ROM_LAT+3 cycles per word (CLIPCHK, FETCH, WAIT×ROM_LAT, WRITE) = 5 cycles at default. 256 words = 1280 cycles from the cycle after start to FIN. A clipped word costs 1 cycle.

Test Plan:
- Copy, sprite_sel=1, dst (0,0), ROM word k = 0x1000+k: 256 writes, addr 0←0x1000, addr 3←0x1003, addr 40←0x1004, addr 2523←0x10FF. done pulses once, 1281 cycles after start. rom_sel=1 throughout.
- Contention: disp_req=1 with disp_addr=0x0123 for 10 cycles while in WRITE. No ram_wr_en during those cycles; ram_addr=0x0123; disp_valid follows one cycle later; the stalled word is written correctly after release; total cycles +10.
- Horizontal clip, dst_wx=38, dst_y=0: only cols 0–1 written, 128 writes; no write reaches addr 40k+38+2 or beyond; done still pulses.
- Vertical clip, dst_y=380, dst_wx=0: rows 0–19 written (80 writes); last write at addr 399*40+3=15963.
- Reset mid-blit after 100 writes: outputs return to reset values next cycle, no done pulse. A new start then completes a full copy normally.
- start pulsed again while busy with different dst: ignored; original destination is completed; exactly one done.
